// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Takes a bundle of instruction fields and packs it into a 32-bit ARM-style
// instruction word. The word goes into a small output FIFO. Two instruction
// classes are supported: data processing (kind=0) and multiply (kind=1).
// A multiply bundle with an unsupported sub-opcode is still consumed, but no
// word is produced; instead err pulses for one cycle.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : field bundle valid
//   in_ready     : encoder can accept a bundle (FIFO not full)
//   kind         : 0 = data processing, 1 = multiply
//   cond         : condition field [31:28]
//   opcode       : data-processing opcode
//   s_bit        : set-flags
//   imm_mode     : operand2 is a rotated immediate
//   reg_shift    : operand2 register shift amount comes from rs
//   rn, rd, rm, rs : register numbers
//   shift_type   : operand2 shift type
//   shift_count  : immediate shift amount
//   rotate       : immediate rotate field
//   imm8         : 8-bit immediate
//   mul_op       : multiply sub-opcode (word bits 23:21)
//   out_valid    : a word is available at the FIFO head
//   out_ready    : consumer takes the head word
//   out_instr    : encoded word at the FIFO head (0 when empty)
//   err          : one-cycle pulse after a rejected bundle
//   enc_count    : number of words enqueued (wraps)
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        kind,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic        imm_mode,
    input  logic        reg_shift,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  shift_count,
    input  logic [3:0]  rotate,
    input  logic [7:0]  imm8,
    input  logic [2:0]  mul_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [15:0] enc_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO state
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Goes high on the first edge after reset release, keeping in_ready low
    // for the whole time reset is asserted.
    logic          run_reg;

    logic          err_reg;
    logic [15:0]   enc_count_reg;

    // Encoder
    logic [31:0]   dp_word;
    logic [31:0]   mul_word;
    logic [31:0]   enc_word;
    logic          mul_legal;
    logic          legal;

    // Handshake
    logic          accept;
    logic          push;
    logic          pop;

    // -----------------------------------------------------------------------
    // Data-processing encoding
    // -----------------------------------------------------------------------
    always_comb begin
        dp_word         = '0;
        dp_word[31:28]  = cond;
        dp_word[27:26]  = 2'b00;
        dp_word[25]     = imm_mode;
        dp_word[24:21]  = opcode;
        dp_word[20]     = s_bit;
        dp_word[19:16]  = rn;
        dp_word[15:12]  = rd;

        if (imm_mode) begin
            dp_word[11:8] = rotate;
            dp_word[7:0]  = imm8;
        end else if (reg_shift) begin
            dp_word[11:8] = rs;
            dp_word[7]    = 1'b0;
            dp_word[6:5]  = shift_type;
            dp_word[4]    = 1'b1;
            dp_word[3:0]  = rm;
        end else begin
            dp_word[11:7] = shift_count;
            dp_word[6:5]  = shift_type;
            dp_word[4]    = 1'b0;
            dp_word[3:0]  = rm;
        end

        // Compare/test ops (10xx) only update flags: S is implied, no rd.
        if (opcode[3:2] == 2'b10) begin
            dp_word[20]    = 1'b1;
            dp_word[15:12] = 4'h0;
        end

        // MOV (1101) and MVN (1111) have no first operand.
        if (opcode[3] && opcode[2] && opcode[0]) begin
            dp_word[19:16] = 4'h0;
        end
    end

    // -----------------------------------------------------------------------
    // Multiply encoding. Note rd/rn occupy swapped positions relative to
    // data processing: rd is in [19:16] and the accumulator rn in [15:12].
    // -----------------------------------------------------------------------
    always_comb begin
        mul_word         = '0;
        mul_word[31:28]  = cond;
        mul_word[27:24]  = 4'b0000;
        mul_word[23:21]  = mul_op;
        mul_word[20]     = s_bit;
        mul_word[19:16]  = rd;
        mul_word[15:12]  = rn;
        mul_word[11:8]   = rs;
        mul_word[7:4]    = 4'b1001;
        mul_word[3:0]    = rm;

        // Plain MUL has no accumulator.
        if (mul_op == 3'b000) begin
            mul_word[15:12] = 4'h0;
        end
    end

    // Supported sub-opcodes: MUL, MLA, UMULL, SMULL.
    always_comb begin
        mul_legal = 1'b0;
        case (mul_op)
            3'b000, 3'b001, 3'b100, 3'b110: mul_legal = 1'b1;
            default:                        mul_legal = 1'b0;
        endcase
    end

    assign legal    = !kind || mul_legal;
    assign enc_word = kind ? mul_word : dp_word;

    // -----------------------------------------------------------------------
    // Handshake and FIFO control
    // -----------------------------------------------------------------------
    assign in_ready  = run_reg && (count_reg < DEPTH_C);
    assign out_valid = (count_reg != '0);

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            enc_count_reg <= '0;
        end else begin
            run_reg   <= 1'b1;
            count_reg <= count_next;
            err_reg   <= accept && !legal;
            if (push) begin
                wr_ptr_reg    <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                enc_count_reg <= enc_count_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; empty entries are masked on the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    assign out_instr = out_valid ? mem[rd_ptr_reg] : 32'h0;
    assign err       = err_reg;
    assign enc_count = enc_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder: encodings with hand-computed words,
// rejection of illegal multiply sub-opcodes, FIFO full/drain order,
// simultaneous push/pop and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        kind;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic        imm_mode;
    logic        reg_shift;
    logic [3:0]  rn, rd, rm, rs;
    logic [1:0]  shift_type;
    logic [4:0]  shift_count;
    logic [3:0]  rotate;
    logic [7:0]  imm8;
    logic [2:0]  mul_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] enc_count;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .kind        (kind),
        .cond        (cond),
        .opcode      (opcode),
        .s_bit       (s_bit),
        .imm_mode    (imm_mode),
        .reg_shift   (reg_shift),
        .rn          (rn),
        .rd          (rd),
        .rm          (rm),
        .rs          (rs),
        .shift_type  (shift_type),
        .shift_count (shift_count),
        .rotate      (rotate),
        .imm8        (imm8),
        .mul_op      (mul_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .err         (err),
        .enc_count   (enc_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic set_dp(input logic [3:0] c, input logic [3:0] op, input logic s,
                          input logic im, input logic rsh, input logic [3:0] n,
                          input logic [3:0] d, input logic [3:0] m, input logic [3:0] sreg,
                          input logic [1:0] st, input logic [4:0] sc,
                          input logic [3:0] rot, input logic [7:0] i8);
        kind = 1'b0; cond = c; opcode = op; s_bit = s; imm_mode = im; reg_shift = rsh;
        rn = n; rd = d; rm = m; rs = sreg; shift_type = st; shift_count = sc;
        rotate = rot; imm8 = i8; mul_op = 3'b000;
    endtask

    task automatic set_mul(input logic [3:0] c, input logic [2:0] mop, input logic s,
                           input logic [3:0] d, input logic [3:0] n,
                           input logic [3:0] sreg, input logic [3:0] m);
        kind = 1'b1; cond = c; mul_op = mop; s_bit = s; rd = d; rn = n; rs = sreg; rm = m;
        opcode = 4'h0; imm_mode = 1'b0; reg_shift = 1'b0; shift_type = 2'b00;
        shift_count = 5'd0; rotate = 4'h0; imm8 = 8'h00;
    endtask

    // Offer the current bundle; waits (bounded) for in_ready, then one edge.
    task automatic send();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_dp(4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 5'd0, 4'h0, 8'h00);
        #3;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check_eq("rst_err",       {31'd0, err},       32'd0);
        check_eq("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check_eq("rst_out_instr", out_instr,          32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD r1, r2, r3
        set_dp(4'hE, 4'b0100, 0, 0, 0, 4'd2, 4'd1, 4'd3, 4'd0, 2'd0, 5'd0, 4'h0, 8'h00);
        send(); exp_cnt++;
        check_eq("add_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add_word",  out_instr, 32'hE0821003);
        check_eq("add_count", {16'd0, enc_count}, exp_cnt);
        pop_one();
        check_eq("add_drained", {31'd0, out_valid}, 32'd0);

        // Directed single-word encodings: fields -> expected word
        set_dp(4'hE, 4'b1101, 0, 1, 0, 4'd7, 4'd0, 4'd0, 4'd0, 2'd0, 5'd0, 4'h0, 8'hFF);
        send(); exp_cnt++;
        check_eq("mov_imm", out_instr, 32'hE3A000FF);
        pop_one();

        set_dp(4'hE, 4'b1010, 0, 1, 0, 4'd1, 4'd9, 4'd0, 4'd0, 2'd0, 5'd0, 4'h0, 8'h05);
        send(); exp_cnt++;
        check_eq("cmp_imm", out_instr, 32'hE3510005);
        pop_one();

        set_dp(4'h0, 4'b0000, 1, 0, 1, 4'd1, 4'd2, 4'd4, 4'd3, 2'd2, 5'd0, 4'h0, 8'h00);
        send(); exp_cnt++;
        check_eq("and_regshift", out_instr, 32'h00112354);
        pop_one();

        set_dp(4'h1, 4'b0001, 0, 0, 0, 4'd5, 4'd6, 4'd7, 4'd0, 2'd3, 5'd31, 4'h0, 8'h00);
        send(); exp_cnt++;
        check_eq("eor_immshift", out_instr, 32'h10256FE7);
        pop_one();

        set_mul(4'hE, 3'b000, 0, 4'd4, 4'd3, 4'd6, 4'd5);
        send(); exp_cnt++;
        check_eq("mul_word", out_instr, 32'hE0040695);
        pop_one();

        set_mul(4'h0, 3'b001, 1, 4'd7, 4'd8, 4'd9, 4'd10);
        send(); exp_cnt++;
        check_eq("mla_word", out_instr, 32'h0037899A);
        pop_one();

        set_mul(4'hE, 3'b100, 0, 4'd1, 4'd2, 4'd3, 4'd4);
        send(); exp_cnt++;
        check_eq("umull_word", out_instr, 32'hE0812394);
        pop_one();

        // Illegal multiply: consumed, err pulse, nothing queued
        set_mul(4'hE, 3'b101, 0, 4'd4, 4'd3, 4'd6, 4'd5);
        send();
        check_eq("bad_mul_err",   {31'd0, err},       32'd1);
        check_eq("bad_mul_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bad_mul_count", {16'd0, enc_count}, exp_cnt);
        @(posedge clk); #1;
        check_eq("bad_mul_err_clear", {31'd0, err}, 32'd0);

        // Fill the FIFO with out_ready low
        set_dp(4'hE, 4'b0100, 0, 0, 0, 4'd2, 4'd1, 4'd3, 4'd0, 2'd0, 5'd0, 4'h0, 8'h00);
        send(); exp_cnt++;
        set_dp(4'hE, 4'b1101, 0, 1, 0, 4'd7, 4'd0, 4'd0, 4'd0, 2'd0, 5'd0, 4'h0, 8'hFF);
        send(); exp_cnt++;
        set_dp(4'hE, 4'b1010, 0, 1, 0, 4'd1, 4'd9, 4'd0, 4'd0, 2'd0, 5'd0, 4'h0, 8'h05);
        send(); exp_cnt++;
        set_mul(4'hE, 3'b000, 0, 4'd4, 4'd3, 4'd6, 4'd5);
        send(); exp_cnt++;
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        // Offer one more while full: must not be taken
        set_dp(4'h1, 4'b0001, 0, 0, 0, 4'd5, 4'd6, 4'd7, 4'd0, 2'd3, 5'd31, 4'h0, 8'h00);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("full_blocked_count", {16'd0, enc_count}, exp_cnt);
        check_eq("full_head_stable", out_instr, 32'hE0821003);
        pop_one();
        check_eq("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("drain_1", out_instr, 32'hE3A000FF);
        pop_one();
        check_eq("drain_2", out_instr, 32'hE3510005);
        pop_one();
        check_eq("drain_3", out_instr, 32'hE0040695);

        // Push and pop in the same cycle with one entry queued
        set_dp(4'h1, 4'b0001, 0, 0, 0, 4'd5, 4'd6, 4'd7, 4'd0, 2'd3, 5'd31, 4'h0, 8'h00);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; exp_cnt++;
        check_eq("pushpop_valid", {31'd0, out_valid}, 32'd1);
        check_eq("pushpop_word",  out_instr, 32'h10256FE7);
        pop_one();
        check_eq("pushpop_empty", {31'd0, out_valid}, 32'd0);
        check_eq("total_count", {16'd0, enc_count}, exp_cnt);

        // Reset with three queued words
        set_dp(4'hE, 4'b0100, 0, 0, 0, 4'd2, 4'd1, 4'd3, 4'd0, 2'd0, 5'd0, 4'h0, 8'h00);
        send(); send(); send();
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_instr", out_instr, 32'd0);
        check_eq("async_rst_count", {16'd0, enc_count}, 32'd0);
        check_eq("async_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_rst_still_empty", {31'd0, out_valid}, 32'd0);
        set_mul(4'h0, 3'b001, 1, 4'd7, 4'd8, 4'd9, 4'd10);
        send();
        check_eq("post_rst_new_word", out_instr, 32'h0037899A);
        check_eq("post_rst_count", {16'd0, enc_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have in_valid/in_ready  input/output  1/1  field-bundle handshake; transfer when both are high at a clk edge.
REQ-005 SHALL have kind  input  1  0 = data processing, 1 = multiply.
REQ-006 SHALL have cond, opcode  input  4/4  condition field and data-processing opcode.
REQ-007 SHALL have s_bit, imm_mode, reg_shift  input  1/1/1  set-flags, immediate operand2, register-specified shift.
REQ-008 SHALL have rn, rd, rm, rs  input  4 each  register numbers.
REQ-009 SHALL have shift_type, shift_count, rotate, imm8  input  2/5/4/8  operand2 fields.
REQ-010 SHALL have mul_op  input  3  multiply sub-opcode (instruction bits 23:21).
REQ-011 SHALL have out_valid/out_ready  output/input  1/1  instruction-word handshake.
REQ-012 SHALL have out_instr  output  32  encoded word at the FIFO head.
REQ-013 SHALL have err  output  1  one-cycle pulse on a rejected bundle.
REQ-014 SHALL have enc_count  output  16  count of words enqueued, wraps at 0xFFFF->0x0000.

Function
REQ-015 in_ready SHALL equal (occupancy < DEPTH); no same-cycle bypass when full.
REQ-016 An accepted legal bundle SHALL be encoded and written to the FIFO tail at that edge; out_valid high the next cycle if the FIFO was empty (latency 1).
REQ-017 out_valid SHALL equal (occupancy > 0); out_instr SHALL be stable while out_valid && !out_ready.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-019 Data processing SHALL encode [31:28]=cond, [27:26]=00, [25]=imm_mode, [24:21]=opcode, [20]=s_bit, [19:16]=rn, [15:12]=rd.
REQ-020 imm_mode=1: [11:8]=rotate, [7:0]=imm8.
REQ-021 imm_mode=0, reg_shift=0: [11:7]=shift_count, [6:5]=shift_type, [4]=0, [3:0]=rm.
REQ-022 imm_mode=0, reg_shift=1: [11:8]=rs, [7]=0, [6:5]=shift_type, [4]=1, [3:0]=rm.
REQ-023 Opcodes 1000-1011 (TST/TEQ/CMP/CMN): bit 20 forced 1, [15:12] forced 0.
REQ-024 Opcodes 1101/1111 (MOV/MVN): [19:16] forced 0.
REQ-025 Multiply SHALL encode [31:28]=cond, [27:24]=0000, [23:21]=mul_op, [20]=s_bit, [19:16]=rd, [15:12]=rn, [11:8]=rs, [7:4]=1001, [3:0]=rm.
REQ-026 Multiply with mul_op 000 (MUL): [15:12] forced 0.
REQ-027 Legal mul_op SHALL be 000, 001, 100, 110; any other value is rejected.
REQ-028 A rejected bundle SHALL still complete the handshake (consumed), SHALL NOT enqueue, SHALL NOT increment enc_count, and SHALL pulse err the following cycle.
REQ-029 kind=0 SHALL never be rejected.
REQ-030 enc_count SHALL increment by 1 per enqueued word.

Reset
REQ-031 rst_n low SHALL immediately clear occupancy and pointers: out_valid=0, err=0, enc_count=0, out_instr=0.
REQ-032 in_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-033 Reset mid-operation SHALL discard all queued words; nothing is emitted after release until new pushes.

Verification
REQ-034 ADD, cond=1110, rd=1, rn=2, rm=3, shift 0, s_bit=0 -> out_instr=0xE0821003 one cycle later; enc_count=1.
REQ-035 MOV, imm_mode=1, rd=0, rn=7, imm8=0xFF, rotate=0 -> 0xE3A000FF (rn forced 0).
REQ-036 CMP, imm_mode=1, rn=1, rd=9, imm8=5, s_bit=0 -> 0xE3510005 (S forced 1, rd forced 0).
REQ-037 kind=1, mul_op=000, rd=4, rm=5, rs=6, rn=3 -> 0xE0040695; then mul_op=101 -> err pulse, no word, enc_count unchanged.
REQ-038 Push 4 with out_ready=0 -> in_ready=0 after 4th; push blocked; one pop -> in_ready=1 next cycle; words drain in order.
REQ-039 Assert rst_n=0 with 3 queued -> out_valid=0 asynchronously; after release, out_valid stays 0 until a new push.
